// File: rtl/vm_change_dispenser.sv
// vm_change_dispenser: change-payout controller for the vending machine.
// Plans a payout from the 10/5/2/1 Rs hoppers, largest coin first and
// limited by stock, then ejects one coin at a time over a valid/ack
// handshake. Also owns the hopper stock counters, refill port and empty flags.
module vm_change_dispenser #(
  parameter int AMT_W       = 5,
  parameter int STOCK_W     = 6,
  parameter int RESET_STOCK = 20,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  input  logic [AMT_W-1:0]       amount_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic                   eject_valid_o,
  output logic [1:0]             eject_coin_o,
  input  logic                   eject_ack_i,
  input  logic                   refill_en_i,
  input  logic [1:0]             refill_sel_i,
  input  logic [STOCK_W-1:0]     refill_cnt_i,
  output logic [4*STOCK_W-1:0]   stock_o,
  output logic [3:0]             empty_o
);

  localparam int CW     = (AMT_W > STOCK_W) ? AMT_W : STOCK_W;
  localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);

  localparam logic [AMT_W-1:0] D1  = AMT_W'(1);
  localparam logic [AMT_W-1:0] D2  = AMT_W'(2);
  localparam logic [AMT_W-1:0] D5  = AMT_W'(5);
  localparam logic [AMT_W-1:0] D10 = AMT_W'(10);

  typedef enum logic [1:0] {
    IDLE,
    PLAN,
    DISPENSE
  } state_e;

  state_e                        state_q;
  logic [3:0][STOCK_W-1:0]       stock_q;
  logic [3:0][AMT_W-1:0]         n_q;
  logic [AMT_W-1:0]              rem_q;
  logic [1:0]                    idx_q;
  logic [1:0]                    ptr_q;
  logic [WAIT_W-1:0]             waitCnt_q;
  logic                          busy_q;
  logic                          done_q;
  logic                          err_q;
  logic                          ejectValid_q;
  logic [1:0]                    ejectCoin_q;

  logic [AMT_W-1:0]              planQuot;
  logic [AMT_W-1:0]              planDen;
  logic [CW-1:0]                 quotW;
  logic [CW-1:0]                 stockW;
  logic [CW-1:0]                 takeW;
  logic [AMT_W-1:0]              planTake;
  logic [AMT_W-1:0]              planRem;
  logic [3:0][AMT_W-1:0]         planN;
  logic [1:0]                    planPtr;
  logic                          planAny;
  logic [1:0]                    lowerPtr;
  logic                          lowerFound;
  logic [STOCK_W:0]              refillSum;
  logic [STOCK_W-1:0]            refillVal;

  // One planning step: take as many coins of the current denomination as the
  // remainder and the hopper allow; division only ever by a constant.
  always_comb begin
    planQuot = '0;
    planDen  = D1;
    case (idx_q)
      2'd3:    begin planQuot = rem_q / D10; planDen = D10; end
      2'd2:    begin planQuot = rem_q / D5;  planDen = D5;  end
      2'd1:    begin planQuot = rem_q / D2;  planDen = D2;  end
      default: begin planQuot = rem_q;       planDen = D1;  end
    endcase
    quotW    = CW'(planQuot);
    stockW   = CW'(stock_q[idx_q]);
    takeW    = (quotW < stockW) ? quotW : stockW;
    planTake = AMT_W'(takeW);
    planRem  = rem_q - planTake * planDen;
  end

  // Coin pointer selection: highest non-empty plan slot after the last step,
  // and the next lower non-empty slot below the current pointer.
  always_comb begin
    planN         = n_q;
    planN[idx_q]  = planTake;
    planPtr       = 2'd0;
    planAny       = 1'b0;
    lowerPtr      = 2'd0;
    lowerFound    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (planN[i] != '0) begin
        planPtr = 2'(i);
        planAny = 1'b1;
      end
      if ((2'(i) < ptr_q) && (n_q[i] != '0)) begin
        lowerPtr   = 2'(i);
        lowerFound = 1'b1;
      end
    end
  end

  // Saturating refill sum for the selected hopper.
  always_comb begin
    refillSum = {1'b0, stock_q[refill_sel_i]} + {1'b0, refill_cnt_i};
    refillVal = refillSum[STOCK_W] ? '1 : refillSum[STOCK_W-1:0];
  end

  // Empty flags follow the stock counters directly.
  always_comb begin
    empty_o = '0;
    for (int i = 0; i < 4; i++) begin
      empty_o[i] = (stock_q[i] == '0);
    end
  end

  // Controller FSM: accept/refill in IDLE, four planning steps, then eject.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      stock_q      <= {4{STOCK_W'(RESET_STOCK)}};
      n_q          <= '0;
      rem_q        <= '0;
      idx_q        <= 2'd3;
      ptr_q        <= 2'd0;
      waitCnt_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      ejectValid_q <= 1'b0;
      ejectCoin_q  <= 2'd0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (refill_en_i) begin
            stock_q[refill_sel_i] <= refillVal;
          end
          if (req_i) begin
            rem_q   <= amount_i;
            n_q     <= '0;
            idx_q   <= 2'd3;
            busy_q  <= 1'b1;
            state_q <= PLAN;
          end
        end
        PLAN: begin
          n_q[idx_q] <= planTake;
          rem_q      <= planRem;
          if (idx_q != 2'd0) begin
            idx_q <= idx_q - 2'd1;
          end else if (planRem != '0) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (!planAny) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            ptr_q        <= planPtr;
            ejectCoin_q  <= planPtr;
            ejectValid_q <= 1'b1;
            waitCnt_q    <= '0;
            state_q      <= DISPENSE;
          end
        end
        DISPENSE: begin
          if (eject_ack_i) begin
            stock_q[ptr_q] <= stock_q[ptr_q] - STOCK_W'(1);
            n_q[ptr_q]     <= n_q[ptr_q] - AMT_W'(1);
            waitCnt_q      <= '0;
            if (n_q[ptr_q] == AMT_W'(1)) begin
              if (lowerFound) begin
                ptr_q       <= lowerPtr;
                ejectCoin_q <= lowerPtr;
              end else begin
                ejectValid_q <= 1'b0;
                done_q       <= 1'b1;
                busy_q       <= 1'b0;
                state_q      <= IDLE;
              end
            end
          end else if (waitCnt_q == WAIT_W'(ACK_TIMEOUT - 1)) begin
            ejectValid_q <= 1'b0;
            err_q        <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end else begin
            waitCnt_q <= waitCnt_q + WAIT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign eject_valid_o = ejectValid_q;
  assign eject_coin_o  = ejectCoin_q;
  assign stock_o       = stock_q;

endmodule

// File: tb/tb_vm_change_dispenser.sv
// tb_vm_change_dispenser: randomized and directed bench for the change
// dispenser with a queue-based scoreboard and an arithmetic payout model.
module tb_vm_change_dispenser;

  localparam int AMT_W       = 5;
  localparam int STOCK_W     = 6;
  localparam int RESET_STOCK = 20;
  localparam int ACK_TIMEOUT = 15;
  localparam int STOCK_MAX   = (1 << STOCK_W) - 1;
  localparam int EV_DONE     = 4;
  localparam int EV_ERR      = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 req;
  logic [AMT_W-1:0]     amount;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic                 eject_valid;
  logic [1:0]           eject_coin;
  logic                 eject_ack;
  logic                 refill_en;
  logic [1:0]           refill_sel;
  logic [STOCK_W-1:0]   refill_cnt;
  logic [4*STOCK_W-1:0] stock_out;
  logic [3:0]           empty;

  int checks = 0;
  int fails  = 0;
  int expQ[$];
  int mStock[4];
  int denom[4] = '{1, 2, 5, 10};
  int ackMode = 0;
  int ackGap  = 0;

  logic       prevValid = 1'b0;
  logic       prevAck   = 1'b0;
  logic [1:0] prevCoin  = 2'd0;

  vm_change_dispenser #(
    .AMT_W(AMT_W), .STOCK_W(STOCK_W), .RESET_STOCK(RESET_STOCK), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .amount_i(amount),
    .busy_o(busy), .done_o(done), .err_o(err),
    .eject_valid_o(eject_valid), .eject_coin_o(eject_coin), .eject_ack_i(eject_ack),
    .refill_en_i(refill_en), .refill_sel_i(refill_sel), .refill_cnt_i(refill_cnt),
    .stock_o(stock_out), .empty_o(empty)
  );

  always #5 clk = ~clk;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Greedy payout by plain arithmetic; returns the unpaid remainder.
  function automatic int planModel(input int amt, output int n[4]);
    int rem = amt;
    for (int i = 3; i >= 0; i--) begin
      n[i] = imin(rem / denom[i], mStock[i]);
      rem  = rem - n[i] * denom[i];
    end
    return rem;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkStock();
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("stock[%0d]", i), int'(stock_out[i*STOCK_W +: STOCK_W]), mStock[i]);
      checkOutput($sformatf("empty[%0d]", i), int'(empty[i]), (mStock[i] == 0) ? 1 : 0);
    end
  endtask

  // Hopper model: acks at random but never leaves a coin waiting long.
  always @(posedge clk) begin
    #1;
    case (ackMode)
      0: eject_ack = 1'b0;
      1: begin
        if (ackGap >= 3 || $urandom_range(0, 99) < 55) begin
          eject_ack = 1'b1;
          ackGap    = 0;
        end else begin
          eject_ack = 1'b0;
          ackGap    = ackGap + 1;
        end
      end
      2: eject_ack = 1'b1;
      default: ;
    endcase
  end

  // Scoreboard monitor: every transfer, done or err pops one expected event.
  always @(negedge clk) begin
    int evt;
    if (rst) begin
      prevValid <= 1'b0;
      prevAck   <= 1'b0;
    end else begin
      if (eject_valid && eject_ack) begin
        if (expQ.size() == 0) begin
          checks++; fails++;
          $display("[TB] FAIL unexpected eject: got coin %0d, expected nothing", eject_coin);
        end else begin
          evt = expQ.pop_front();
          checkOutput("eject coin", int'(eject_coin), evt);
        end
      end
      if (done || err) begin
        checkOutput("done/err exclusive", int'(done && err), 0);
        if (expQ.size() == 0) begin
          checks++; fails++;
          $display("[TB] FAIL unexpected end: got done=%0d err=%0d, expected nothing", done, err);
        end else begin
          evt = expQ.pop_front();
          checkOutput("end event", done ? EV_DONE : EV_ERR, evt);
        end
      end
      if (prevValid && !prevAck && eject_valid) begin
        checkOutput("coin held while waiting", int'(eject_coin), int'(prevCoin));
      end
      prevValid <= eject_valid;
      prevAck   <= eject_ack;
      prevCoin  <= eject_coin;
    end
  end

  // One payout transaction: model the outcome, drive req, time the response.
  task automatic applyStimulus(input int amt, input bit immediate, input bit sameRefill,
                               input int rSel, input int rCnt, input bit busyRefill);
    int  n[4];
    int  rem;
    int  coins = 0;
    int  expLat = -1;
    int  firstValid = 0;
    int  endK = 0;
    bit  dispense = 1'b0;
    if (sameRefill) mStock[rSel] = imin(mStock[rSel] + rCnt, STOCK_MAX);
    rem = planModel(amt, n);
    for (int i = 0; i < 4; i++) coins += n[i];
    if (rem != 0) begin
      expQ.push_back(EV_ERR); expLat = 5;
    end else if (coins == 0) begin
      expQ.push_back(EV_DONE); expLat = 5;
    end else if (ackMode == 0) begin
      expQ.push_back(EV_ERR); expLat = 5 + ACK_TIMEOUT; dispense = 1'b1;
    end else begin
      dispense = 1'b1;
      for (int i = 3; i >= 0; i--) begin
        repeat (n[i]) expQ.push_back(i);
        mStock[i] -= n[i];
      end
      expQ.push_back(EV_DONE);
      if (ackMode == 2) expLat = 5 + coins;
    end
    if (!immediate) begin
      @(posedge clk); #1;
    end
    req        = 1'b1;
    amount     = AMT_W'(amt);
    refill_en  = sameRefill;
    refill_sel = 2'(rSel);
    refill_cnt = STOCK_W'(rCnt);
    @(posedge clk); #1;
    req       = 1'b0;
    refill_en = busyRefill;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) checkOutput("busy after req", int'(busy), 1);
      if (k == 3) refill_en = 1'b0;
      if (eject_valid && firstValid == 0) firstValid = k;
      if (done || err) begin
        endK = k;
        break;
      end
    end
    refill_en = 1'b0;
    if (endK == 0) begin
      checks++; fails++;
      $display("[TB] FAIL txn end: got no done/err in 200 cycles, expected one (amount %0d)", amt);
    end else begin
      if (expLat > 0) checkOutput("end latency", endK, expLat);
      checkOutput("first valid cycle", firstValid, dispense ? 5 : 0);
      checkOutput("busy at end", int'(busy), 0);
      checkOutput("valid at end", int'(eject_valid), 0);
    end
    checkStock();
  endtask

  task automatic doRefill(input int sel, input int cnt);
    @(posedge clk); #1;
    refill_en  = 1'b1;
    refill_sel = 2'(sel);
    refill_cnt = STOCK_W'(cnt);
    @(posedge clk); #1;
    refill_en = 1'b0;
    mStock[sel] = imin(mStock[sel] + cnt, STOCK_MAX);
    @(negedge clk);
    checkStock();
  endtask

  // Spend coins of one denomination only until its hopper reaches target.
  task automatic drainTo(input int code, input int target);
    int maxk[4] = '{1, 2, 1, 3};
    while (mStock[code] > target) begin
      applyStimulus(denom[code] * imin(mStock[code] - target, maxk[code]), 1'b0, 1'b0, 0, 0, 1'b0);
    end
  endtask

  task automatic resetMidDispense();
    int  n[4];
    int  first = -1;
    bit  seen = 1'b0;
    void'(planModel(15, n));
    for (int i = 0; i < 4; i++) if (n[i] != 0) first = i;
    ackMode   = 3;
    eject_ack = 1'b0;
    expQ.push_back(first);
    @(posedge clk); #1;
    req = 1'b1; amount = AMT_W'(15);
    @(posedge clk); #1;
    req = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (eject_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++; fails++;
      $display("[TB] FAIL reset test valid: got no eject_valid in 20 cycles, expected one");
    end
    @(posedge clk); #1;
    eject_ack = 1'b1;
    @(posedge clk); #1;
    eject_ack = 1'b0;
    rst = 1'b1;
    expQ.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) mStock[i] = RESET_STOCK;
    @(negedge clk);
    checkOutput("post-reset valid", int'(eject_valid), 0);
    checkOutput("post-reset busy", int'(busy), 0);
    checkOutput("post-reset done", int'(done), 0);
    checkOutput("post-reset err", int'(err), 0);
    checkStock();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; req = 1'b0; amount = '0; eject_ack = 1'b0;
    refill_en = 1'b0; refill_sel = 2'd0; refill_cnt = '0;
    for (int i = 0; i < 4; i++) mStock[i] = RESET_STOCK;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset err", int'(err), 0);
    checkOutput("reset valid", int'(eject_valid), 0);
    checkOutput("reset coin", int'(eject_coin), 0);
    checkStock();

    $display("[TB] amount 18, ack every cycle");
    ackMode = 2;
    applyStimulus(18, 1'b0, 1'b0, 0, 0, 1'b0);

    $display("[TB] shaping stock to s10=1 s5=0 s2=5 s1=0");
    ackMode = 1;
    drainTo(3, 1); drainTo(2, 0); drainTo(1, 5); drainTo(0, 0);
    ackMode = 2;
    applyStimulus(20, 1'b0, 1'b0, 0, 0, 1'b0);

    $display("[TB] infeasible and zero amounts");
    doRefill(1, 5);
    applyStimulus(3, 1'b0, 1'b0, 0, 0, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, 0, 0, 1'b0);

    $display("[TB] ack timeout");
    doRefill(2, 10);
    ackMode = 0;
    applyStimulus(7, 1'b0, 1'b0, 0, 0, 1'b0);

    $display("[TB] refill saturation, refill while busy, refill with req");
    doRefill(0, 60);
    doRefill(0, 10);
    ackMode = 1;
    applyStimulus(7, 1'b0, 1'b0, 3, 5, 1'b1);
    applyStimulus(20, 1'b0, 1'b1, 3, 2, 1'b0);

    $display("[TB] reset mid-dispense");
    resetMidDispense();

    $display("[TB] randomized payouts");
    ackMode = 1;
    for (int t = 0; t < 60; t++) begin
      bit imm = 1'(($urandom_range(0, 1)));
      if (!imm) repeat ($urandom_range(0, 2)) @(posedge clk);
      applyStimulus($urandom_range(0, 31), imm, ($urandom_range(0, 3) == 0),
                    $urandom_range(0, 3), $urandom_range(0, 40), ($urandom_range(0, 4) == 0));
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboard drained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
